// File: rtl/regfile_fwd_if.sv
// Write-back, EX-forward and decode read signals of the MIPS32 register file.
// No valid/ready pair: every write and read is taken in the cycle it is presented, with no back-pressure.
interface regfile_fwd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_waddr;
    logic [DATA_W-1:0] ex_wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [15:0]       wr_count;

    modport master (
        output we, waddr, wdata,
        output ex_we, ex_waddr, ex_wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, wr_count
    );

    modport slave (
        input  we, waddr, wdata,
        input  ex_we, ex_waddr, ex_wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, wr_count
    );
endinterface

// File: rtl/regfile_fwd.sv
// 32x32 register file with $0 tied to zero and EX/WB forwarding onto two
// combinational decode read ports.
module regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic           clk,
    input  logic           rst,
    regfile_fwd_if.slave   bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [15:0]       count_q;
    logic              commit;

    // Writes to $0 are dropped entirely, so they neither store nor count.
    assign commit = bus.we && (bus.waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (commit && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.wr_count = count_q;

    // EX result is newer than the WB write, so it is checked first.
    always_comb begin
        bus.rdata1 = '0;
        if (!rst || !bus.re1 || (bus.raddr1 == '0)) begin
            bus.rdata1 = '0;
        end else if (bus.ex_we && (bus.ex_waddr == bus.raddr1)) begin
            bus.rdata1 = bus.ex_wdata;
        end else if (bus.we && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
        end else begin
            bus.rdata1 = regs[bus.raddr1];
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (!rst || !bus.re2 || (bus.raddr2 == '0)) begin
            bus.rdata2 = '0;
        end else if (bus.ex_we && (bus.ex_waddr == bus.raddr2)) begin
            bus.rdata2 = bus.ex_wdata;
        end else if (bus.we && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
        end else begin
            bus.rdata2 = regs[bus.raddr2];
        end
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: driver pushes expected read/count values,
// a negedge monitor pops and compares them.
module tb_regfile_fwd;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EXP_W  = 2 * DATA_W + 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_fwd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model: architectural register contents and commit count
  logic [DATA_W-1:0] m_regs [32];
  int unsigned       m_count;

  logic [EXP_W-1:0] exp_q [$];
  string            tag_q [$];
  int               checks = 0;
  int               errors = 0;

  function automatic logic [DATA_W-1:0] model_read(input logic en, input logic [ADDR_W-1:0] ra);
    if (!rst) return '0;
    if (!en) return '0;
    if (ra == 0) return '0;
    if (bus.ex_we && bus.ex_waddr == ra) return bus.ex_wdata;
    if (bus.we && bus.waddr == ra) return bus.wdata;
    return m_regs[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_count = 0;
  endtask

  task automatic model_commit();
    if (rst && bus.we && bus.waddr != 0) begin
      m_regs[bus.waddr] = bus.wdata;
      if (m_count < 65535) m_count++;
    end
  endtask

  // driver tasks
  task automatic set_idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.ex_we = 1'b0; bus.ex_waddr = '0; bus.ex_wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
  endtask

  task automatic drop_reset();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic step(input string tag);
    logic [15:0] c;
    c = m_count[15:0];
    exp_q.push_back({model_read(bus.re1, bus.raddr1), model_read(bus.re2, bus.raddr2), c});
    tag_q.push_back(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic quiet_step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // scoreboard monitor
  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/rdata1"}, bus.rdata1, e[EXP_W-1 -: DATA_W]);
      check({t, "/rdata2"}, bus.rdata2, e[16 +: DATA_W]);
      check({t, "/wr_count"}, {16'h0, bus.wr_count}, {16'h0, e[15:0]});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    set_idle();
    drop_reset();
    @(posedge clk); #1;

    // reset holds reads at zero even with a write and matching read presented
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hCAFE0001;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    step("reset_hold");
    set_idle();
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.re1 = 1'b1; bus.raddr1 = 5'(i);
      bus.re2 = 1'b1; bus.raddr2 = 5'(32 - i);
      step($sformatf("post_reset_r%0d", i));
    end

    set_idle();
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hDEADBEEF;
    step("write_r3");
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    step("read_r3");

    set_idle();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h12345678;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    step("zero_write_during");
    bus.we = 1'b0;
    step("zero_write_after");
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd0; bus.ex_wdata = 32'h87654321;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    step("zero_ex_forward");

    set_idle();
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'd1;
    step("write_r7_1");
    bus.wdata = 32'd2;
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd7; bus.ex_wdata = 32'd3;
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    step("fwd_ex_over_wb");
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    step("fwd_wb_committed");

    set_idle();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5A5A5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    bus.re1 = 1'b0; bus.raddr1 = 5'd9;
    step("wb_write_through");
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd9; bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    step("same_reg_both_ports");

    set_idle();
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h55;
    step("write_r4");
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    step("read_r4");
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h77;
    drop_reset();
    step("async_reset_mid");
    rst = 1'b1;
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    step("after_async_reset");

    // randomized traffic, addresses mostly in a small window to force collisions
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) drop_reset();
      else rst = 1'b1;
      bus.we = 1'($urandom_range(0, 1));
      bus.waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.wdata = $urandom();
      bus.ex_we = 1'($urandom_range(0, 1));
      bus.ex_waddr = 5'($urandom_range(0, 7));
      bus.ex_wdata = $urandom();
      bus.re1 = ($urandom_range(0, 4) != 0);
      bus.raddr1 = 5'($urandom_range(0, 7));
      bus.re2 = ($urandom_range(0, 4) != 0);
      bus.raddr2 = ($urandom_range(0, 1) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
      step($sformatf("random_%0d", n));
    end

    // drive the commit counter into saturation
    rst = 1'b1;
    set_idle();
    bus.we = 1'b1;
    for (int n = 0; n < 65600; n++) begin
      bus.waddr = 5'(1 + (n % 31));
      bus.wdata = $urandom();
      quiet_step();
    end
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd31; bus.re2 = 1'b1; bus.raddr2 = 5'd1;
    step("count_saturated");
    bus.we = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'h0BADF00D;
    step("write_at_saturation");
    set_idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd2;
    step("read_after_saturation");

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- 32 x 32-bit general-purpose register file for the MIPS32 core; the receiving end of the writeReg/writeAddr/writeData bundle the execute path produces.
- Accepts one write-back per cycle from the WB stage and serves two decode-stage read ports.
- Read data is forwarded from the in-flight EX-stage result and the current WB write, so decode sees the newest value without stalling on ALU-to-ALU dependencies.
- Register $0 is hard-wired to zero.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (rst==0 resets)
- we  in  1  WB write enable (writeReg from MEM/WB)
- waddr  in  ADDR_W  WB write address
- wdata  in  DATA_W  WB write data
- ex_we  in  1  EX-stage writeReg_o (result in flight)
- ex_waddr  in  ADDR_W  EX-stage writeAddr_o
- ex_wdata  in  DATA_W  EX-stage writeData_o
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- wr_count  out  16  count of committed writes since reset, saturating

Behaviour:
- Reset (rst==0, asynchronous):
  - all 32 registers clear to 0; wr_count clears to 0.
  - rdata1/rdata2 read 0 while reset is asserted, regardless of other inputs.
- Write:
  - On the rising clk edge with we==1 and waddr!=0, regs[waddr] <= wdata, and wr_count increments by 1, saturating at 16'hFFFF.
  - A write with waddr==0 is discarded and is not counted.
  - we==0 leaves the array unchanged.
- Read ports: combinational, zero-cycle latency. Each port evaluates in this priority order:
  1. rst==0 -> 0
  2. reN==0 -> 0
  3. raddrN==0 -> 0 ($0 always reads zero, even when it is forwarded or written)
  4. ex_we==1 and ex_waddr==raddrN -> ex_wdata (newest value)
  5. we==1 and waddr==raddrN -> wdata (write-through in the same cycle)
  6. otherwise -> regs[raddrN]
- EX and WB both targeting the same address as a read: the EX value wins (step 4 before step 5). The WB write still commits to the array on the clock edge.
- Both read ports may address the same register and both get identical data.
- EX forwarding never writes the array. Only the WB port commits state.
- Reset asserted mid-write: the array is cleared and the pending edge is ignored. Writes resume on the first clk edge after rst returns to 1.
- No X propagation: every output has a defined value in all input combinations.

Test Plan:
- Reset: hold rst=0, then drive re1=1, raddr1=5 -> rdata1=0. Release rst; read all 31 registers -> every value is 0; wr_count=0.
- Basic write/read: we=1, waddr=3, wdata=32'hDEADBEEF, one edge; next cycle we=0, re1=1, raddr1=3 -> rdata1=32'hDEADBEEF; wr_count=1.
- $0 protection: we=1, waddr=0, wdata=32'h12345678 -> reading raddr2=0 gives 0 both during and after the edge; wr_count is unchanged. ex_we=1, ex_waddr=0 -> read of $0 still 0.
- Forwarding priority: regs[7]=1; drive we=1, waddr=7, wdata=2 and ex_we=1, ex_waddr=7, ex_wdata=3 -> rdata1 (raddr1=7) = 3. Next cycle with ex_we=0, we=0 -> rdata1=2.
- WB write-through: we=1, waddr=9, wdata=32'hA5A5A5A5; same cycle re2=1, raddr2=9 -> rdata2=32'hA5A5A5A5 before the clock edge. Same result with re1=0, where rdata1=0.
- Async reset mid-operation: after writing regs[4]=32'h55, drop rst between clock edges -> rdata1 (raddr1=4) goes to 0 immediately. After release, regs[4] reads 0 and wr_count=0.
